// File: rtl/nibble_serial_alu_ctrl_if.sv
// Bundles the request/result handshake of the nibble-serial ALU sequencer
// together with the nibble-wide link to the external 4-bit add/sub ALU.
interface nibble_serial_alu_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         op_sub;
  logic         op_cin;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         res_cf;
  logic         res_zf;
  logic         res_vf;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_c0;
  logic         alu_as;
  logic [3:0]   alu_f;
  logic         alu_c4;

  modport master (
    output start, op_sub, op_cin, op_a, op_b, alu_f, alu_c4,
    input  busy, done, res, res_cf, res_zf, res_vf, alu_a, alu_b, alu_c0, alu_as
  );

  modport slave (
    input  start, op_sub, op_cin, op_a, op_b, alu_f, alu_c4,
    output busy, done, res, res_cf, res_zf, res_vf, alu_a, alu_b, alu_c0, alu_as
  );
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Runs W-bit add/sub through an external 4-bit ALU one nibble per clock, LSB first.
// Define ALU_SEQ_OVF_EN to enable the signed-overflow flag res_vf.
module nibble_serial_alu_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_alu_ctrl_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, acc_q, res_q;
  logic               sub_q, carry_q, cf_q, zf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       acc_nxt;
  logic               last_nib;

  // Each returned nibble enters at the top; after NIBBLES captures the LSB nibble sits at the bottom.
  assign acc_nxt  = (acc_q >> 4) | (W'(bus.alu_f) << (W - 4));
  assign last_nib = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.alu_a   = 4'h0;
    bus.alu_b   = 4'h0;
    bus.alu_c0  = 1'b0;
    bus.alu_as  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        bus.busy   = 1'b1;
        bus.alu_a  = a_q[3:0];
        bus.alu_b  = b_q[3:0];
        bus.alu_c0 = carry_q;
        bus.alu_as = sub_q;
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_q     <= bus.op_a;
          b_q     <= bus.op_b;
          sub_q   <= bus.op_sub;
          // Subtract is A + ~B + 1, so borrow-in maps to an inverted carry-in.
          carry_q <= bus.op_sub ? ~bus.op_cin : bus.op_cin;
          cnt_q   <= '0;
        end
        RUN: begin
          acc_q   <= acc_nxt;
          carry_q <= bus.alu_c4;
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          cnt_q   <= cnt_q + 1'b1;
          if (last_nib) begin
            res_q <= acc_nxt;
            cf_q  <= sub_q ^ bus.alu_c4;
            zf_q  <= (acc_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.res    = res_q;
  assign bus.res_cf = cf_q;
  assign bus.res_zf = zf_q;

`ifdef ALU_SEQ_OVF_EN
  logic vf_q;

  // Top-nibble signed overflow: operands agree in sign but the sum does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vf_q <= 1'b0;
    else if (state_q == RUN && last_nib)
      vf_q <= (a_q[3] == (b_q[3] ^ sub_q)) && (bus.alu_f[3] != a_q[3]);
  end

  assign bus.res_vf = vf_q;
`else
  assign bus.res_vf = 1'b0;
`endif
endmodule
